// File: rtl/hpdl1414_writer_if.sv
// Byte input and HPDL-1414 display bus bundle for hpdl1414_writer.
interface hpdl1414_writer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [6:0] disp_d;
    logic [1:0] disp_a;
    logic       disp_wr_n;
    logic       busy;
    logic       overflow;

    modport master (
        output rx_valid, rx_data,
        input  disp_d, disp_a, disp_wr_n, busy, overflow
    );

    modport slave (
        input  rx_valid, rx_data,
        output disp_d, disp_a, disp_wr_n, busy, overflow
    );
endinterface

// File: rtl/hpdl1414_writer.sv
// Scrolling 4-char shadow buffer that rewrites an HPDL-1414 display
// with timed WR_n strobes for every printable byte received.
module hpdl1414_writer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input logic             clk,
    input logic             rst,
    hpdl1414_writer_if.slave bus
);
    typedef enum logic [2:0] {
        INIT, IDLE, LOAD, SETUP, STROBE, HOLD
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [6:0] SPACE      = 7'h20;

    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [3:0][6:0] shadow, shadow_nxt;
    logic            load_disp;

    logic [7:0]      hold;
    logic            hold_full;
    logic            overflow;
    logic            consume;

    logic [6:0]      disp_d;
    logic [1:0]      disp_a;
    logic            wr_n;
    logic            busy;

    logic            printable;
    logic            is_ff;
    logic [6:0]      glyph;

    assign consume   = (state == LOAD);
    assign printable = ~hold[7] & (hold[6:5] != 2'b00);
    assign is_ff     = (hold == 8'h0C);
    // 0x60..0x7F fold onto 0x40..0x5F by clearing bit 5
    assign glyph     = {hold[6], hold[5] & ~hold[6], hold[4:0]};

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        load_disp  = 1'b0;
        unique case (state)
            INIT: begin
                state_nxt = SETUP;
                cnt_nxt   = 8'd0;
                idx_nxt   = 2'd0;
                load_disp = 1'b1;
            end
            IDLE: begin
                if (hold_full) state_nxt = LOAD;
            end
            LOAD: begin
                cnt_nxt = 8'd0;
                idx_nxt = 2'd0;
                if (printable || is_ff) begin
                    if (printable) shadow_nxt = {shadow[2:0], glyph};
                    else           shadow_nxt = {4{SPACE}};
                    state_nxt = SETUP;
                    load_disp = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = STROBE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            STROBE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt = 8'd0;
                    if (idx == 2'd3) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = SETUP;
                        load_disp = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Outputs are registered from the next state so WR_n is a clean flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INIT;
            cnt    <= 8'd0;
            idx    <= 2'd0;
            shadow <= {4{SPACE}};
            disp_d <= SPACE;
            disp_a <= 2'd0;
            wr_n   <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            if (load_disp) begin
                disp_a <= idx_nxt;
                disp_d <= shadow_nxt[idx_nxt];
            end
            wr_n <= (state_nxt != STROBE);
            busy <= (state_nxt == LOAD) || (state_nxt == SETUP) ||
                    (state_nxt == STROBE) || (state_nxt == HOLD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= 8'd0;
            hold_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (consume) hold_full <= 1'b0;
            if (bus.rx_valid) begin
                if (!hold_full || consume) begin
                    hold      <= bus.rx_data;
                    hold_full <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.disp_d    = disp_d;
    assign bus.disp_a    = disp_a;
    assign bus.disp_wr_n = wr_n;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_hpdl1414_writer.sv
// Directed bench for hpdl1414_writer: watches every WR_n strobe for
// setup/pulse/hold timing and keeps a model of what the display shows.
module tb_hpdl1414_writer;
    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 2;
    localparam int HOLD_CYC  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hpdl1414_writer_if bus();

    hpdl1414_writer #(
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic [6:0] shown [4];
    logic [7:0] seq = 8'd0;
    int         nwrites = 0;

    logic       pw = 1'b1;
    logic [1:0] pa = 2'd0;
    logic [6:0] pd = 7'h20;
    int         setup_run = 0;
    int         lo_run = 0;
    int         hold_run = 0;
    bit         hold_on = 1'b0;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            pw = 1'b1; pa = 2'd0; pd = 7'h20;
            setup_run = 0; lo_run = 0;
            hold_run = 0; hold_on = 1'b0;
        end else begin
            if (!bus.disp_wr_n) begin
                if (pw) begin
                    chk("setup", 32'(setup_run), 32'(SETUP_CYC));
                    lo_run = 1;
                end else begin
                    chk("a_low", 32'(bus.disp_a), 32'(pa));
                    chk("d_low", 32'(bus.disp_d), 32'(pd));
                    lo_run++;
                end
            end else if (!pw) begin
                chk("pulse", 32'(lo_run), 32'(PULSE_CYC));
                chk("a_rise", 32'(bus.disp_a), 32'(pa));
                chk("d_rise", 32'(bus.disp_d), 32'(pd));
                shown[pa] = pd;
                seq = {seq[5:0], pa};
                nwrites++;
                hold_on = 1'b1;
                hold_run = 1;
            end else begin
                if (hold_on) begin
                    if (bus.busy && bus.disp_a == pa && bus.disp_d == pd) begin
                        hold_run++;
                    end else begin
                        chk("hold", 32'(hold_run), 32'(HOLD_CYC));
                        hold_on = 1'b0;
                    end
                end
                if (!bus.busy)
                    setup_run = 0;
                else if (bus.disp_a != pa || bus.disp_d != pd)
                    setup_run = 1;
                else
                    setup_run++;
            end
            pw = bus.disp_wr_n;
            pa = bus.disp_a;
            pd = bus.disp_d;
        end
    end

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int t;
        t = 0;
        while (!bus.busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        lat = t;
        chk("busy_rise", 32'(bus.busy), 32'd1);
        t = 0;
        while (bus.busy && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk("busy_fall", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_all_space(input string tag);
        for (int i = 0; i < 4; i++)
            chk(tag, 32'(shown[i]), 32'h20);
    endtask

    initial begin
        int lat;
        int hi;
        int t;
        logic [7:0] abcd [4];
        abcd[0] = 8'h41; abcd[1] = 8'h42;
        abcd[2] = 8'h43; abcd[3] = 8'h44;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 4; i++) shown[i] = 7'h00;

        repeat (3) @(negedge clk);
        chk("rst_wr_n", 32'(bus.disp_wr_n), 32'd1);
        chk("rst_d", 32'(bus.disp_d), 32'h20);
        chk("rst_a", 32'(bus.disp_a), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);

        rst = 1'b0;
        wait_done(lat);
        chk("init_lat", 32'(lat), 32'd1);
        chk("init_writes", 32'(nwrites), 32'd4);
        chk("init_seq", 32'(seq), 32'h1B);
        chk_all_space("init_d");
        chk("init_ovf", 32'(bus.overflow), 32'd0);

        for (int i = 0; i < 4; i++) begin
            nwrites = 0;
            send(abcd[i]);
            wait_done(lat);
            chk("abcd_writes", 32'(nwrites), 32'd4);
            chk("abcd_seq", 32'(seq), 32'h1B);
        end
        chk("abcd_a0", 32'(shown[0]), 32'h44);
        chk("abcd_a1", 32'(shown[1]), 32'h43);
        chk("abcd_a2", 32'(shown[2]), 32'h42);
        chk("abcd_a3", 32'(shown[3]), 32'h41);

        send(8'h61);
        wait_done(lat);
        chk("fold_a0", 32'(shown[0]), 32'h41);
        send(8'h7F);
        wait_done(lat);
        chk("del_a0", 32'(shown[0]), 32'h5F);
        chk("del_a1", 32'(shown[1]), 32'h41);
        chk("del_a2", 32'(shown[2]), 32'h44);
        chk("del_a3", 32'(shown[3]), 32'h43);

        nwrites = 0;
        send(8'h0D);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy) hi++;
        end
        chk("cr_busy", 32'(hi), 32'd1);
        send(8'h85);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy) hi++;
        end
        chk("hi_busy", 32'(hi), 32'd1);
        chk("ign_writes", 32'(nwrites), 32'd0);
        chk("ign_a", 32'(bus.disp_a), 32'd3);
        chk("ign_d", 32'(bus.disp_d), 32'h43);
        chk("ign_wr_n", 32'(bus.disp_wr_n), 32'd1);

        send(8'h0C);
        wait_done(lat);
        chk("ff_writes", 32'(nwrites), 32'd4);
        chk_all_space("ff_d");
        chk("ff_ovf", 32'(bus.overflow), 32'd0);

        send(8'h51);
        repeat (4) @(negedge clk);
        send(8'h58);
        send(8'h59);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        wait_done(lat);
        chk("q_a0", 32'(shown[0]), 32'h51);
        nwrites = 0;
        wait_done(lat);
        chk("x_gap", 32'(lat), 32'd1);
        chk("x_writes", 32'(nwrites), 32'd4);
        chk("x_a0", 32'(shown[0]), 32'h58);
        chk("x_a1", 32'(shown[1]), 32'h51);
        chk("x_a2", 32'(shown[2]), 32'h20);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("y_dropped", 32'(bus.busy), 32'd0);

        send(8'h5A);
        t = 0;
        while (bus.disp_wr_n && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_low", 32'(bus.disp_wr_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_wr_n", 32'(bus.disp_wr_n), 32'd1);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 4; i++) shown[i] = 7'h00;
        repeat (2) @(negedge clk);
        nwrites = 0;
        seq = 8'd0;
        rst = 1'b0;
        wait_done(lat);
        chk("reinit_writes", 32'(nwrites), 32'd4);
        chk("reinit_seq", 32'(seq), 32'h1B);
        chk_all_space("reinit_d");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
